cond_select_pipe: RTL
=====================

# cond_select_pipe

Parametrised conditional data selector with a valid/ready handshake on both sides. Each transaction captures NUM_CH input words and produces one result word, either a selected channel or a two-operand arithmetic result. A sticky error flag records range and configuration faults. It sits between multi-source datapath producers and a single downstream consumer, and generalises the team's fixed 3-input, mode-driven selector to N channels, round-robin selection and flow control.

## Interface
- DATA_W, 8, width of each data word
- NUM_CH, 4, number of input channels (≥2)
- THRESH, 2**(DATA_W-1), range threshold; a selected word strictly greater than THRESH flags an error
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- mode  input  2  00 FIXED, 01 PRIORITY, 10 ROUND_ROBIN, 11 ARITH; sampled at accept
- ch_sel  input  $clog2(NUM_CH)  channel index for FIXED
- ch_mask  input  NUM_CH  channel enable mask
- op_sub  input  1  ARITH: 0 = ch0+ch1, 1 = ch0−ch1
- in_valid  input  1  input transaction valid
- in_ready  output  1  block can accept
- in_data  input  NUM_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W]
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts
- out_data  output  DATA_W  result
- out_ch  output  $clog2(NUM_CH)  granted channel; 0 in ARITH
- err_clr  input  1  clears error_flag
- error_flag  output  1  sticky error

## Operation
- States:
  - IDLE: in_ready=1. Accept on in_valid&in_ready; register in_data, mode, ch_sel, ch_mask, op_sub; go to EVAL.
  - EVAL: compute result into output registers, then go to OUT. On an empty grant, return to IDLE with no output.
  - OUT: out_valid=1 until out_ready; on out_valid&out_ready go to IDLE.
- Channel grant rules:
  - FIXED: grant ch_sel if ch_mask[ch_sel]=1, else empty grant.
  - PRIORITY: grant the lowest-index set bit of ch_mask; empty if mask=0.
  - ROUND_ROBIN: grant the first set bit at or after rr_ptr, searching upward with wrap. On a grant, rr_ptr ← (grant+1) mod NUM_CH. rr_ptr changes only on a ROUND_ROBIN grant.
  - ARITH: ch_mask is ignored.
- Arithmetic is computed DATA_W+1 wide:
  - Add overflows when the carry is set.
  - Subtract underflows when ch0<ch1.
- error_flag is set in EVAL when any of the following holds:
  - empty grant;
  - the selected word is greater than THRESH (FIXED, PRIORITY or ROUND_ROBIN); the result is still delivered;
  - ARITH overflow or underflow.
- error_flag is cleared by err_clr. When set and clear occur in the same cycle, set wins.
- out_data and out_ch stay stable while out_valid=1 and out_ready=0.

## Timing
- Reset (rst_n=0 at an edge) gives:
  - state IDLE, rr_ptr 0;
  - out_valid 0, out_data 0, out_ch 0, error_flag 0;
  - in_ready 0 while rst_n=0.
- Reset mid-transaction discards the transaction.
- in_ready is 1 exactly in IDLE with rst_n=1, including the first cycle after reset release.
- Latency: accept at edge t, error_flag update at t+1, out_valid high after edge t+1, available for transfer in cycle t+2.
- Throughput: with out_ready held at 1, one transaction per 3 cycles. Empty grant: next accept 2 cycles after the previous one.
- The input side never accepts while OUT is pending; there is no skid buffer.

## Configuration
- COND_SAT_EN defined: ARITH saturates, overflow gives all-ones and underflow gives 0.
- COND_SAT_EN undefined: ARITH wraps modulo 2**DATA_W.
- error_flag behaviour is identical in both builds.

## Structure
- Package cond_select_pkg holds:
  - the mode_e enum (FIXED, PRIORITY, ROUND_ROBIN, ARITH);
  - the state_e enum (IDLE, EVAL, OUT);
  - the MODE_W=2 constant.
- Sub-module cond_rr_arbiter: combinational find-first-set starting at a pointer, with wrap.
  - Inputs: mask, start pointer.
  - Outputs: grant index, any.
  - PRIORITY uses it with start 0; ROUND_ROBIN uses it with rr_ptr.

## Test plan
All scenarios use DATA_W=8, NUM_CH=4, THRESH=0x80.
- FIXED, ch_sel=2, mask=0100, ch2=0x5A → out_data 0x5A, out_ch 2, out_valid after edge t+1, error_flag 0.
- PRIORITY, mask=1010, ch1=0x81 → out_ch 1, out_data 0x81, error_flag 1. PRIORITY, mask=0000 → no out_valid, error_flag 1, next accept at t+2. err_clr pulse → error_flag 0.
- ROUND_ROBIN, mask=1011, four back-to-back transactions → out_ch 0,1,3,0. Interleaved FIXED transactions leave the sequence unchanged.
- ARITH, add 0xF0+0x20 → 0xFF with COND_SAT_EN or 0x10 without, error_flag 1 in both. Subtract 0x10−0x20 → 0x00 or 0xF0. Add 0x10+0x20 → 0x30, no error.
- Backpressure: out_ready=0 for 5 cycles in OUT → out_valid, out_data and out_ch stable; in_ready 0 throughout; transfer on the first cycle with out_ready=1, in_ready 1 the next cycle.
- rst_n=0 for one edge during OUT → out_valid 0 and state IDLE after that edge, in_ready 1 the cycle after rst_n=1. err_clr and a new error in the same cycle → error_flag remains 1.

Source files
------------

// File: rtl/cond_select_pkg.sv
// Shared types for the conditional selector: operating modes and FSM states.
package cond_select_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        FIXED       = 2'b00,
        PRIORITY    = 2'b01,
        ROUND_ROBIN = 2'b10,
        ARITH       = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        OUT  = 2'd2
    } state_e;

endpackage

// File: rtl/cond_rr_arbiter.sv
// Combinational find-first-set over a channel mask, starting at a pointer and
// wrapping past the top channel. start must be below NUM_CH.
module cond_rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   start,
    output logic [CH_W-1:0]   grant,
    output logic              any
);

    localparam logic [CH_W:0] NUM_CH_V = (CH_W+1)'(NUM_CH);

    // cand_idx[gi] is the channel sitting gi places after start, wrapped.
    logic [CH_W-1:0] cand_idx [NUM_CH];
    logic [NUM_CH-1:0] cand_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_cand
            logic [CH_W:0] sum;
            assign sum          = {1'b0, start} + (CH_W+1)'(gi);
            assign cand_idx[gi] = (sum >= NUM_CH_V) ? CH_W'(sum - NUM_CH_V) : CH_W'(sum);
            assign cand_hit[gi] = mask[cand_idx[gi]];
        end
    endgenerate

    // Scan from the farthest offset down so the nearest hit is the one kept.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                grant = cand_idx[i];
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cond_select_arbiter.sv
// Unused stub module; the channel arbiter is implemented in cond_rr_arbiter.sv.
module cond_select_arbiter_unused;
endmodule

// File: rtl/cond_select_pipe.sv
// N-channel conditional selector / two-operand ALU with valid/ready on both sides.
// Build option: define COND_SAT_EN to saturate ARITH results instead of wrapping.
module cond_select_pipe
    import cond_select_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int THRESH = 2**(DATA_W-1),
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [MODE_W-1:0]        mode,
    input  logic [CH_W-1:0]          ch_sel,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic                     op_sub,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    input  logic                     err_clr,
    output logic                     error_flag
);

    localparam logic [DATA_W:0] THRESH_V = (DATA_W+1)'(THRESH);
    localparam logic [CH_W:0]   NUM_CH_V = (CH_W+1)'(NUM_CH);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

    state_e                    state_reg;
    mode_e                     mode_reg;
    logic [NUM_CH*DATA_W-1:0]  data_reg;
    logic [CH_W-1:0]           ch_sel_reg;
    logic [NUM_CH-1:0]         mask_reg;
    logic                      op_sub_reg;
    logic [CH_W-1:0]           rr_ptr_reg;
    logic [DATA_W-1:0]         out_data_reg;
    logic [CH_W-1:0]           out_ch_reg;
    logic                      error_flag_reg;
    logic                      error_flag_next;

    logic [DATA_W-1:0] data_words [NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_words
            assign data_words[gi] = data_reg[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // One arbiter serves both PRIORITY (start 0) and ROUND_ROBIN (start rr_ptr).
    logic [CH_W-1:0] arb_start;
    logic [CH_W-1:0] arb_grant;
    logic            arb_any;

    assign arb_start = (mode_reg == ROUND_ROBIN) ? rr_ptr_reg : '0;

    cond_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .mask  (mask_reg),
        .start (arb_start),
        .grant (arb_grant),
        .any   (arb_any)
    );

    logic [CH_W-1:0]   sel_idx;
    logic              sel_any;
    logic [DATA_W-1:0] sel_word;
    logic [DATA_W:0]   arith_sum;
    logic [DATA_W:0]   arith_diff;
    logic [DATA_W-1:0] arith_res;
    logic              arith_err;
    logic [DATA_W-1:0] eval_data;
    logic [CH_W-1:0]   eval_ch;
    logic              eval_any;
    logic              eval_err;

    always_comb begin
        // An out-of-range FIXED index is treated as an empty grant.
        sel_idx  = (mode_reg == FIXED) ? ch_sel_reg : arb_grant;
        sel_any  = (mode_reg == FIXED)
                 ? (({1'b0, ch_sel_reg} < NUM_CH_V) && mask_reg[ch_sel_reg])
                 : arb_any;
        sel_word = data_words[sel_idx];

        arith_sum  = {1'b0, data_words[0]} + {1'b0, data_words[1]};
        arith_diff = {1'b0, data_words[0]} - {1'b0, data_words[1]};
        arith_err  = op_sub_reg ? arith_diff[DATA_W] : arith_sum[DATA_W];
`ifdef COND_SAT_EN
        if (arith_err) begin
            arith_res = op_sub_reg ? '0 : '1;
        end else begin
            arith_res = op_sub_reg ? arith_diff[DATA_W-1:0] : arith_sum[DATA_W-1:0];
        end
`else
        arith_res = op_sub_reg ? arith_diff[DATA_W-1:0] : arith_sum[DATA_W-1:0];
`endif

        if (mode_reg == ARITH) begin
            eval_data = arith_res;
            eval_ch   = '0;
            eval_any  = 1'b1;
            eval_err  = arith_err;
        end else begin
            eval_data = sel_word;
            eval_ch   = sel_idx;
            eval_any  = sel_any;
            eval_err  = !sel_any || ({1'b0, sel_word} > THRESH_V);
        end
    end

    // A new fault in EVAL takes precedence over a simultaneous clear.
    always_comb begin
        error_flag_next = error_flag_reg;
        if (err_clr) begin
            error_flag_next = 1'b0;
        end
        if (state_reg == EVAL && eval_err) begin
            error_flag_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            mode_reg       <= FIXED;
            data_reg       <= '0;
            ch_sel_reg     <= '0;
            mask_reg       <= '0;
            op_sub_reg     <= 1'b0;
            rr_ptr_reg     <= '0;
            out_data_reg   <= '0;
            out_ch_reg     <= '0;
            error_flag_reg <= 1'b0;
        end else begin
            error_flag_reg <= error_flag_next;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        mode_reg   <= mode_e'(mode);
                        data_reg   <= in_data;
                        ch_sel_reg <= ch_sel;
                        mask_reg   <= ch_mask;
                        op_sub_reg <= op_sub;
                        state_reg  <= EVAL;
                    end
                end
                EVAL: begin
                    if (eval_any) begin
                        out_data_reg <= eval_data;
                        out_ch_reg   <= eval_ch;
                        state_reg    <= OUT;
                        if (mode_reg == ROUND_ROBIN) begin
                            rr_ptr_reg <= (arb_grant == LAST_CH) ? '0 : arb_grant + 1'b1;
                        end
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready   = rst_n && (state_reg == IDLE);
    assign out_valid  = (state_reg == OUT);
    assign out_data   = out_data_reg;
    assign out_ch     = out_ch_reg;
    assign error_flag = error_flag_reg;

endmodule
